// File: rtl/genius_pkg.sv
// Shared encodings and defaults for the Genius sprite controller.
package genius_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_IDLE,
        ST_SHOW,
        ST_GAP,
        ST_LOSE,
        ST_WIN
    } state_t;

    localparam int FLAG_PWR        = 0;
    localparam int FLAG_WIN        = 1;
    localparam int FLAG_LOSE       = 2;
    localparam int FLAG_COLOR_BASE = 3;

    localparam int DEF_NUM_COLORS    = 4;
    localparam int DEF_HOLD_CYCLES   = 16;
    localparam int DEF_GAP_CYCLES    = 4;
    localparam int DEF_RESULT_CYCLES = 64;

endpackage

// File: rtl/genius_down_counter.sv
// Loadable down-counter that saturates at zero.
module genius_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge CLK) begin
        if (RESET)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/genius_sprite_ctrl.sv
// Sprite sequencer for the Genius game: shows colours, result screens and power state.
module genius_sprite_ctrl
    import genius_pkg::*;
#(
    parameter int NUM_COLORS    = DEF_NUM_COLORS,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int RESULT_CYCLES = DEF_RESULT_CYCLES,
    localparam int CW = (NUM_COLORS > 2) ? $clog2(NUM_COLORS) : 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    PWR_BTN,
    input  logic                    SHOW_VALID,
    input  logic [CW-1:0]           SHOW_COLOR,
    output logic                    SHOW_READY,
    input  logic                    GAME_LOSE,
    input  logic                    GAME_WIN,
    output logic                    SHOW_ERR,
    output logic [NUM_COLORS+2:0]   SPRITES_FLAGS
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES)
                           ? ((HOLD_CYCLES > RESULT_CYCLES) ? HOLD_CYCLES : RESULT_CYCLES)
                           : ((GAP_CYCLES > RESULT_CYCLES) ? GAP_CYCLES : RESULT_CYCLES);
    localparam int CNTW   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam int GAP_M1 = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int FW     = NUM_COLORS + 3;
    localparam logic [CW:0] NC_W = (CW+1)'(NUM_COLORS);

    state_t          state, nxt;
    logic [CW-1:0]   col_q, nxt_col;
    logic            transfer, bad_color;
    logic            cnt_load, cnt_zero;
    logic [CNTW-1:0] cnt_value, cnt_load_value;

    function automatic logic [FW-1:0] flags_of(state_t s, logic [CW-1:0] c);
        flags_of = '0;
        case (s)
            ST_IDLE, ST_GAP: flags_of[FLAG_PWR] = 1'b1;
            ST_SHOW: begin
                flags_of[FLAG_PWR] = 1'b1;
                for (int unsigned i = 0; i < NUM_COLORS; i++)
                    if (c == CW'(i))
                        flags_of[FLAG_COLOR_BASE + NUM_COLORS - 1 - i] = 1'b1;
            end
            ST_LOSE: flags_of[FLAG_LOSE] = 1'b1;
            ST_WIN:  flags_of[FLAG_WIN]  = 1'b1;
            default: flags_of = '0;
        endcase
    endfunction

    assign SHOW_READY = (state == ST_IDLE) && !GAME_LOSE && !GAME_WIN && !PWR_BTN;
    assign transfer   = SHOW_VALID && SHOW_READY;
    assign bad_color  = transfer && ({1'b0, SHOW_COLOR} >= NC_W);
    assign nxt_col    = transfer ? SHOW_COLOR : col_q;

    always_comb begin
        nxt = state;
        case (state)
            ST_OFF:
                if (PWR_BTN) nxt = ST_IDLE;
            ST_IDLE:
                if (GAME_LOSE)                  nxt = ST_LOSE;
                else if (GAME_WIN)              nxt = ST_WIN;
                else if (PWR_BTN)               nxt = ST_OFF;
                else if (transfer && !bad_color) nxt = ST_SHOW;
            ST_SHOW:
                if (GAME_LOSE)     nxt = ST_LOSE;
                else if (GAME_WIN) nxt = ST_WIN;
                else if (cnt_zero) nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:
                if (GAME_LOSE)     nxt = ST_LOSE;
                else if (GAME_WIN) nxt = ST_WIN;
                else if (cnt_zero) nxt = ST_IDLE;
            ST_LOSE:
                if (cnt_zero && !GAME_LOSE) nxt = ST_OFF;
            ST_WIN:
                if (cnt_zero && !GAME_WIN) nxt = ST_OFF;
            default: nxt = ST_OFF;
        endcase
    end

    // No state re-enters itself, so a state change marks every entry that needs a reload.
    always_comb begin
        cnt_load       = (nxt != state);
        cnt_load_value = '0;
        case (nxt)
            ST_SHOW:         cnt_load_value = CNTW'(HOLD_CYCLES - 1);
            ST_GAP:          cnt_load_value = CNTW'(GAP_M1);
            ST_LOSE, ST_WIN: cnt_load_value = CNTW'(RESULT_CYCLES - 1);
            default:         cnt_load_value = '0;
        endcase
    end

    genius_down_counter #(.WIDTH(CNTW)) u_counter (
        .CLK        (CLK),
        .RESET      (RESET),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (!cnt_load),
        .count      (cnt_value),
        .zero       (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= ST_OFF;
            col_q         <= '0;
            SHOW_ERR      <= 1'b0;
            SPRITES_FLAGS <= '0;
        end else begin
            state         <= nxt;
            col_q         <= nxt_col;
            SHOW_ERR      <= bad_color;
            SPRITES_FLAGS <= flags_of(nxt, nxt_col);
        end
    end

endmodule

// File: tb/tb_genius_sprite_ctrl.sv
// Directed bench for genius_sprite_ctrl: a default instance and a five-colour instance.
module tb_genius_sprite_ctrl;

    logic       CLK = 1'b0;
    logic       rst, pwr, valid, lose, win;
    logic [1:0] col;
    logic       rdy, err;
    logic [6:0] flags;

    logic       rst5, pwr5, valid5, lose5, win5;
    logic [2:0] col5;
    logic       rdy5, err5;
    logic [7:0] flags5;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    genius_sprite_ctrl dut (
        .CLK(CLK), .RESET(rst), .PWR_BTN(pwr), .SHOW_VALID(valid), .SHOW_COLOR(col),
        .SHOW_READY(rdy), .GAME_LOSE(lose), .GAME_WIN(win), .SHOW_ERR(err),
        .SPRITES_FLAGS(flags)
    );

    genius_sprite_ctrl #(.NUM_COLORS(5)) dut5 (
        .CLK(CLK), .RESET(rst5), .PWR_BTN(pwr5), .SHOW_VALID(valid5), .SHOW_COLOR(col5),
        .SHOW_READY(rdy5), .GAME_LOSE(lose5), .GAME_WIN(win5), .SHOW_ERR(err5),
        .SPRITES_FLAGS(flags5)
    );

    typedef struct {
        logic       pwr, valid;
        logic [1:0] col;
        logic       lose, win;
        logic       rdy;
        logic [6:0] flags;
        logic       err;
    } vec_t;

    vec_t vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        pwr = 0; valid = 0; col = 0; lose = 0; win = 0;
    endtask

    // Runs n edges, checking the flags after each one.
    task automatic hold_check(input string name, input logic [6:0] exp, input int n);
        for (int k = 0; k < n; k++) begin
            step();
            check(name, 32'(flags), 32'(exp));
        end
    endtask

    initial begin
        vt[0] = '{0, 0, 2'd0, 0, 0, 0, 7'b0000000, 0};
        vt[1] = '{0, 1, 2'd1, 0, 0, 0, 7'b0000000, 0};
        vt[2] = '{1, 0, 2'd0, 0, 0, 0, 7'b0000001, 0};
        vt[3] = '{0, 0, 2'd0, 0, 0, 1, 7'b0000001, 0};
        vt[4] = '{1, 1, 2'd1, 0, 0, 0, 7'b0000000, 0};
        vt[5] = '{1, 0, 2'd0, 0, 0, 0, 7'b0000001, 0};
        vt[6] = '{0, 1, 2'd1, 1, 1, 0, 7'b0000100, 0};

        rst = 1; idle_inputs();
        rst5 = 1; pwr5 = 0; valid5 = 0; col5 = 0; lose5 = 0; win5 = 0;
        step(); step();

        // Five-colour instance: out-of-range request and the highest legal colour.
        check("reset5_flags", 32'(flags5), 32'h0);
        rst5 = 0; pwr5 = 1;
        step();
        check("pwr5_flags", 32'(flags5), 32'h01);
        pwr5 = 0; valid5 = 1; col5 = 3'd6;
        #1 check("bad_ready5", 32'(rdy5), 32'd1);
        step();
        check("bad_err5", 32'(err5), 32'd1);
        check("bad_flags5", 32'(flags5), 32'h01);
        valid5 = 0;
        step();
        check("bad_err5_drop", 32'(err5), 32'd0);
        check("bad_idle5", 32'(rdy5), 32'd1);
        valid5 = 1; col5 = 3'd4;
        step();
        check("col4_flags5", 32'(flags5), 32'b00001001);
        check("col4_err5", 32'(err5), 32'd0);
        valid5 = 0;

        // Default instance: reset state then single-cycle vectors.
        check("reset_flags", 32'(flags), 32'h0);
        check("reset_err", 32'(err), 32'd0);
        rst = 0;
        for (int i = 0; i < 7; i++) begin
            pwr = vt[i].pwr; valid = vt[i].valid; col = vt[i].col;
            lose = vt[i].lose; win = vt[i].win;
            #1 check($sformatf("vec%0d_ready", i), 32'(rdy), 32'(vt[i].rdy));
            step();
            check($sformatf("vec%0d_flags", i), 32'(flags), 32'(vt[i].flags));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].err));
        end
        idle_inputs();
        hold_check("lose_min_hold", 7'b0000100, 63);
        hold_check("lose_to_off", 7'b0000000, 1);

        // Colour 2 transfer: lit 16 cycles, 4-cycle gap, then ready again.
        pwr = 1; step(); pwr = 0;
        valid = 1; col = 2'd2;
        #1 check("t_ready", 32'(rdy), 32'd1);
        step();
        valid = 0;
        check("show_t1", 32'(flags), 32'b0010001);
        hold_check("show_hold", 7'b0010001, 15);
        for (int k = 0; k < 4; k++) begin
            step();
            check("gap_flags", 32'(flags), 32'b0000001);
            check("gap_ready", 32'(rdy), 32'd0);
        end
        step();
        check("t21_ready", 32'(rdy), 32'd1);
        check("t21_flags", 32'(flags), 32'b0000001);

        // Loss five cycles into a colour, held for 100 cycles.
        valid = 1; col = 2'd0;
        step();
        valid = 0;
        check("col0_flags", 32'(flags), 32'b1000001);
        hold_check("col0_hold", 7'b1000001, 4);
        lose = 1;
        hold_check("lose_hold", 7'b0000100, 100);
        lose = 0;
        hold_check("lose_release", 7'b0000000, 1);

        // One-cycle win pulse in IDLE.
        pwr = 1; step(); pwr = 0;
        win = 1; step(); win = 0;
        check("win_entry", 32'(flags), 32'b0000010);
        hold_check("win_hold", 7'b0000010, 63);
        hold_check("win_to_off", 7'b0000000, 1);

        // Win during the gap abandons it; PWR_BTN is ignored while showing.
        pwr = 1; step(); pwr = 0;
        valid = 1; col = 2'd3;
        step();
        valid = 0;
        check("col3_flags", 32'(flags), 32'b0001001);
        pwr = 1;
        hold_check("col3_pwr_ignored", 7'b0001001, 15);
        pwr = 0;
        hold_check("col3_gap", 7'b0000001, 1);
        win = 1;
        hold_check("gap_to_win", 7'b0000010, 1);
        win = 0;

        // Reset mid-SHOW, then requests need a power pulse first.
        rst = 1; step(); rst = 0;
        pwr = 1; step(); pwr = 0;
        valid = 1; col = 2'd1;
        step();
        valid = 0;
        check("col1_flags", 32'(flags), 32'b0100001);
        step(); step();
        rst = 1;
        step();
        check("rst_mid_flags", 32'(flags), 32'h0);
        check("rst_mid_err", 32'(err), 32'd0);
        rst = 0;
        valid = 1; col = 2'd1;
        for (int k = 0; k < 2; k++) begin
            #1 check("post_rst_ready", 32'(rdy), 32'd0);
            step();
            check("post_rst_off", 32'(flags), 32'h0);
        end
        valid = 0; pwr = 1;
        step();
        pwr = 0; valid = 1;
        #1 check("post_pwr_ready", 32'(rdy), 32'd1);
        step();
        valid = 0;
        check("post_pwr_show", 32'(flags), 32'b0100001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
